mem_arbiter_rr: RTL and testbench

Parametrised round-robin arbiter that shares one memory request channel among NUM_REQ cache clients (I-cache, D-cache, and later ptw/prefetch ports). It replaces the fixed two-way I/D arbiter in front of the AXI memory interface. The block holds each grant for a whole transaction, from request handshake to response, and tags every request with the winner's index. Sits between the L1 caches and the AXI read/write adapter.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/rr_picker.sv | 40 ++++
 rtl/mem_arbiter_rr.sv | 83 ++++++++
 tb/tb_mem_arbiter_rr.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the round-robin memory request arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arb_state_t;

    localparam int unsigned DEF_NUM_REQ = 2;
    localparam int unsigned DEF_ADDR_W  = 64;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: rotate req so last+1 sits at bit 0, take the lowest set bit,
// rotate the one-hot back and recover its absolute index.
module rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic [IDX_W-1:0]   start;
    logic [NUM_REQ-1:0] rotated;
    logic [NUM_REQ-1:0] rot_oh;
    logic [IDX_W-1:0]   rot_idx;
    logic [IDX_W:0]     idx_sum;

    always_comb begin
        start   = (last >= IDX_W'(NUM_REQ - 1)) ? '0 : last + 1'b1;
        rotated = NUM_REQ'({req, req} >> start);
        // Isolate lowest set bit: x & -x
        rot_oh  = rotated & (~rotated + 1'b1);

        rot_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rot_oh[i]) begin
                rot_idx = IDX_W'(i);
            end
        end

        idx_sum = {1'b0, rot_idx} + {1'b0, start};
        if (idx_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            idx_sum = idx_sum - (IDX_W + 1)'(NUM_REQ);
        end
        winner_idx = idx_sum[IDX_W-1:0];
        winner     = NUM_REQ'(({rot_oh, rot_oh} << start) >> NUM_REQ);
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one memory request channel among NUM_REQ cache clients.
// A grant is held for a whole transaction, from request handshake until its response returns.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]             req_write,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [ADDR_W-1:0]              m_addr,
    output logic                           m_write,
    output logic [ID_W-1:0]                m_id,
    input  logic                           m_resp_valid
);

    arb_state_t         state;
    logic [ID_W-1:0]    last;
    logic [NUM_REQ-1:0] pick_oh;
    logic [ID_W-1:0]    pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_picker (
        .req        (req),
        .last       (last),
        .winner     (pick_oh),
        .winner_idx (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            last    <= ID_W'(NUM_REQ - 1);
            grant   <= '0;
            done    <= '0;
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_write <= 1'b0;
            m_id    <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= pick_oh;
                        m_addr  <= req_addr[pick_idx];
                        m_write <= req_write[pick_idx];
                        m_id    <= pick_idx;
                        m_valid <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A response can't precede its own handshake, so m_resp_valid is ignored here
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (m_resp_valid) begin
                        done  <= grant;
                        grant <= '0;
                        last  <= m_id;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a 2-client instance for protocol cases, a 4-client one
// for round-robin order.
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // 2-client instance
    logic [1:0]       req2 = '0;
    logic [1:0][63:0] addr2 = '0;
    logic [1:0]       wr2 = '0;
    logic [1:0]       grant2, done2;
    logic             mv2, mw2;
    logic             mr2 = 1'b0;
    logic             rv2 = 1'b0;
    logic [63:0]      ma2;
    logic [0:0]       id2;

    // 4-client instance
    logic [3:0]       req4 = '0;
    logic [3:0][63:0] addr4 = '0;
    logic [3:0]       wr4 = '0;
    logic [3:0]       grant4, done4;
    logic             mv4, mw4;
    logic             mr4 = 1'b0;
    logic             rv4 = 1'b0;
    logic [63:0]      ma4;
    logic [1:0]       id4;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter_rr #(.NUM_REQ(2), .ADDR_W(64)) u_dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req2),
        .req_addr     (addr2),
        .req_write    (wr2),
        .grant        (grant2),
        .done         (done2),
        .m_valid      (mv2),
        .m_ready      (mr2),
        .m_addr       (ma2),
        .m_write      (mw2),
        .m_id         (id2),
        .m_resp_valid (rv2)
    );

    mem_arbiter_rr #(.NUM_REQ(4), .ADDR_W(64)) u_dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req4),
        .req_addr     (addr4),
        .req_write    (wr4),
        .grant        (grant4),
        .done         (done4),
        .m_valid      (mv4),
        .m_ready      (mr4),
        .m_addr       (ma4),
        .m_write      (mw4),
        .m_id         (id4),
        .m_resp_valid (rv4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the 2-client DUT with req already driven; returns in the done cycle.
    task automatic txn2(input string tag, input logic [1:0] exp_grant, input logic exp_id,
                        input logic [63:0] exp_addr);
        tick();
        check({tag, " grant"}, 64'(grant2), 64'(exp_grant));
        check({tag, " m_valid"}, 64'(mv2), 64'd1);
        check({tag, " m_id"}, 64'(id2), 64'(exp_id));
        check({tag, " m_addr"}, ma2, exp_addr);
        mr2 = 1'b1;
        tick();
        mr2 = 1'b0;
        check({tag, " m_valid after hs"}, 64'(mv2), 64'd0);
        check({tag, " grant held"}, 64'(grant2), 64'(exp_grant));
        rv2 = 1'b1;
        tick();
        rv2 = 1'b0;
        check({tag, " done"}, 64'(done2), 64'(exp_grant));
        check({tag, " grant cleared"}, 64'(grant2), 64'd0);
    endtask

    task automatic txn4(input string tag, input logic [3:0] exp_grant, input logic [1:0] exp_id,
                        input logic [63:0] exp_addr);
        tick();
        check({tag, " grant"}, 64'(grant4), 64'(exp_grant));
        check({tag, " m_id"}, 64'(id4), 64'(exp_id));
        check({tag, " m_addr"}, ma4, exp_addr);
        mr4 = 1'b1;
        tick();
        mr4 = 1'b0;
        rv4 = 1'b1;
        tick();
        rv4 = 1'b0;
        check({tag, " done"}, 64'(done4), 64'(exp_grant));
    endtask

    initial begin
        #3;
        check("reset grant", 64'(grant2), 64'd0);
        check("reset m_valid", 64'(mv2), 64'd0);
        check("reset m_addr", ma2, 64'd0);
        check("reset m_id", 64'(id2), 64'd0);
        check("reset done", 64'(done2), 64'd0);
        #4 reset_n = 1'b1;
        tick();

        // Contention from reset: strict alternation starting with client 0
        addr2[0] = 64'hA0;
        addr2[1] = 64'hB0;
        req2 = 2'b11;
        txn2("cont0", 2'b01, 1'b0, 64'hA0);
        txn2("cont1", 2'b10, 1'b1, 64'hB0);
        txn2("cont2", 2'b01, 1'b0, 64'hA0);
        req2 = 2'b00;
        tick();
        check("cont idle m_valid", 64'(mv2), 64'd0);
        check("cont idle done", 64'(done2), 64'd0);

        // Commit: client 1 drops req and changes address while in ISSUE
        addr2[1] = 64'h2000;
        wr2[1]   = 1'b1;
        req2     = 2'b10;
        tick();
        check("commit grant", 64'(grant2), 64'h2);
        check("commit m_write", 64'(mw2), 64'd1);
        req2     = 2'b00;
        addr2[1] = 64'hDEAD;
        tick();
        check("commit m_addr", ma2, 64'h2000);
        check("commit m_valid", 64'(mv2), 64'd1);
        // Stray response alongside handshake: only the handshake counts
        mr2 = 1'b1;
        rv2 = 1'b1;
        tick();
        mr2 = 1'b0;
        rv2 = 1'b0;
        check("stray rv done", 64'(done2), 64'd0);
        check("stray rv m_valid", 64'(mv2), 64'd0);
        tick();
        check("commit grant held", 64'(grant2), 64'h2);
        rv2 = 1'b1;
        tick();
        rv2 = 1'b0;
        check("commit done", 64'(done2), 64'h2);
        tick();
        check("commit done pulse", 64'(done2), 64'd0);

        // Stray inputs while idle
        rv2 = 1'b1;
        mr2 = 1'b1;
        tick();
        tick();
        rv2 = 1'b0;
        mr2 = 1'b0;
        check("idle stray m_valid", 64'(mv2), 64'd0);
        check("idle stray grant", 64'(grant2), 64'd0);
        check("idle stray done", 64'(done2), 64'd0);

        // Single requester with a held-off handshake
        addr2[0] = 64'h1000;
        wr2[0]   = 1'b0;
        req2     = 2'b01;
        tick();
        check("single grant", 64'(grant2), 64'h1);
        check("single m_addr", ma2, 64'h1000);
        check("single m_id", 64'(id2), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single stall m_valid", 64'(mv2), 64'd1);
            check("single stall m_addr", ma2, 64'h1000);
            check("single stall grant", 64'(grant2), 64'h1);
        end
        mr2 = 1'b1;
        tick();
        mr2 = 1'b0;
        check("single m_valid low", 64'(mv2), 64'd0);
        rv2 = 1'b1;
        tick();
        rv2 = 1'b0;
        req2 = 2'b00;
        check("single done", 64'(done2), 64'h1);
        tick();
        check("single done pulse", 64'(done2), 64'd0);

        // Async reset mid-WAIT_RESP; last is 0 here, so only a reset pointer gives 01 next
        req2 = 2'b10;
        tick();
        mr2 = 1'b1;
        tick();
        mr2 = 1'b0;
        req2 = 2'b00;
        check("pre-reset grant", 64'(grant2), 64'h2);
        #2 reset_n = 1'b0;
        #1;
        check("async grant", 64'(grant2), 64'd0);
        check("async m_addr", ma2, 64'd0);
        check("async m_id", 64'(id2), 64'd0);
        check("async m_valid", 64'(mv2), 64'd0);
        #2 reset_n = 1'b1;
        req2 = 2'b11;
        tick();
        check("post-reset grant", 64'(grant2), 64'h1);
        check("post-reset done", 64'(done2), 64'd0);
        req2 = 2'b00;
        mr2 = 1'b1;
        tick();
        mr2 = 1'b0;
        rv2 = 1'b1;
        tick();
        rv2 = 1'b0;
        check("post-reset txn done", 64'(done2), 64'h1);
        tick();

        // Four clients all requesting: 0,1,2,3,0
        for (int i = 0; i < 4; i++) begin
            addr4[i] = 64'(32'h100 * (i + 1));
        end
        req4 = 4'b1111;
        txn4("rr4 0", 4'b0001, 2'd0, 64'h100);
        txn4("rr4 1", 4'b0010, 2'd1, 64'h200);
        txn4("rr4 2", 4'b0100, 2'd2, 64'h300);
        txn4("rr4 3", 4'b1000, 2'd3, 64'h400);
        txn4("rr4 4", 4'b0001, 2'd0, 64'h100);
        req4 = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
